dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache for the MEM stage.

---
 rtl/dcache_ctrl_pkg.sv | 31 +++
 rtl/dcache_ctrl_if.sv | 44 ++++
 rtl/dcache_line_store.sv | 72 +++++++
 rtl/dcache_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dcache_ctrl_pkg
//   Shared definitions for the direct-mapped write-back data cache:
//   controller state encoding, default geometry and the derived field widths.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package dcache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBACK = 2'd1,
        FILL  = 2'd2
    } state_t;

    // Byte offset inside a 64-bit word; these address bits never reach the cache.
    localparam int OFFSET_LSB = 3;

    localparam int DEF_INDEX_BITS    = 4;
    localparam int DEF_WORD_OFF_BITS = 2;
    localparam int DEF_ADDR_W        = 64;
    localparam int DEF_DATA_W        = 64;

    function automatic int calc_tag_w(input int addr_w, input int index_bits,
                                      input int word_off_bits);
        return addr_w - index_bits - word_off_bits - OFFSET_LSB;
    endfunction

    localparam int TAG_W      = calc_tag_w(DEF_ADDR_W, DEF_INDEX_BITS, DEF_WORD_OFF_BITS);
    localparam int LINE_WORDS = 1 << DEF_WORD_OFF_BITS;

endpackage

// File: rtl/dcache_ctrl_if.sv
// -----------------------------------------------------------------------------
// dcache_ctrl_if
//   Single-beat req/ack main-memory port of the data cache.
//   Signals:
//     mem_req   cache -> mem  beat request
//     mem_we    cache -> mem  1 = write beat, 0 = read beat
//     mem_addr  cache -> mem  word-aligned beat address
//     mem_wdata cache -> mem  write-beat data
//     mem_rdata mem -> cache  read-beat data, valid with mem_ack
//     mem_ack   mem -> cache  beat completes this cycle
//   Modports: master (cache side), slave (memory side).
// -----------------------------------------------------------------------------
interface dcache_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    import dcache_ctrl_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/dcache_line_store.sv
// -----------------------------------------------------------------------------
// dcache_line_store
//   Storage for the cache: per-line data words, tag, valid and dirty bits.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset (valid/dirty only)
//     rd_idx                combinational read index
//     rd_tag/valid/dirty    state of line rd_idx
//     rd_line               all words of line rd_idx
//     wr_en, wr_idx,
//     wr_word, wr_data      synchronous single-word write
//     set_dirty             with wr_en: mark the line dirty (store hit)
//     fill_done, fill_tag   install fill_tag at wr_idx, valid=1, dirty=0
// -----------------------------------------------------------------------------
module dcache_line_store
    import dcache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS    = DEF_INDEX_BITS,
    parameter int WORD_OFF_BITS = DEF_WORD_OFF_BITS,
    parameter int TAG_BITS      = TAG_W,
    parameter int DATA_W        = DEF_DATA_W
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [INDEX_BITS-1:0]                      rd_idx,
    output logic [TAG_BITS-1:0]                        rd_tag,
    output logic                                       rd_valid,
    output logic                                       rd_dirty,
    output logic [(1<<WORD_OFF_BITS)-1:0][DATA_W-1:0]  rd_line,
    input  logic                                       wr_en,
    input  logic [INDEX_BITS-1:0]                      wr_idx,
    input  logic [WORD_OFF_BITS-1:0]                   wr_word,
    input  logic [DATA_W-1:0]                          wr_data,
    input  logic                                       set_dirty,
    input  logic                                       fill_done,
    input  logic [TAG_BITS-1:0]                        fill_tag
);
    localparam int NUM_LINES = 1 << INDEX_BITS;
    localparam int NWORDS    = 1 << WORD_OFF_BITS;

    logic [NWORDS-1:0][DATA_W-1:0] data_mem [NUM_LINES];
    logic [TAG_BITS-1:0]           tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0]          valid;
    logic [NUM_LINES-1:0]          dirty;

    assign rd_line  = data_mem[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];

    // Data and tags carry no reset; valid=0 makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx][wr_word] <= wr_data;
        end
        if (fill_done) begin
            tag_mem[wr_idx] <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_done) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= 1'b0;
        end else if (wr_en && set_dirty) begin
            dirty[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate data cache for the MEM stage.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     mem_read     load request          mem_write  store request
//     addr         byte address          wdata      store data
//     rdata        load data (valid when hit=1 and mem_read=1)
//     hit          1 = access done / no access, 0 = stall the pipeline
//     mem          main-memory port (dcache_ctrl_if.master)
//   A miss writes back a dirty victim line first, then refills the line one
//   word per acknowledged beat; the retried access then hits.
// -----------------------------------------------------------------------------
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS    = DEF_INDEX_BITS,
    parameter int WORD_OFF_BITS = DEF_WORD_OFF_BITS,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               hit,
    dcache_ctrl_if.master      mem
);
    localparam int TAG_BITS = calc_tag_w(ADDR_W, INDEX_BITS, WORD_OFF_BITS);
    localparam int NWORDS   = 1 << WORD_OFF_BITS;

    // Request address fields
    logic [TAG_BITS-1:0]      cpu_tag;
    logic [INDEX_BITS-1:0]    cpu_idx;
    logic [WORD_OFF_BITS-1:0] cpu_word;
    logic                     unused_byte_off;

    assign cpu_word = addr[OFFSET_LSB +: WORD_OFF_BITS];
    assign cpu_idx  = addr[OFFSET_LSB + WORD_OFF_BITS +: INDEX_BITS];
    assign cpu_tag  = addr[ADDR_W-1 -: TAG_BITS];
    assign unused_byte_off = ^addr[OFFSET_LSB-1:0];

    // Controller state
    state_t                   state, state_n;
    logic [WORD_OFF_BITS-1:0] beat, beat_n;
    logic [TAG_BITS-1:0]      req_tag;
    logic [INDEX_BITS-1:0]    req_idx;
    logic                     latch_req;

    // Line store ports
    logic [INDEX_BITS-1:0]            rd_idx;
    logic [TAG_BITS-1:0]              rd_tag;
    logic                             rd_valid;
    logic                             rd_dirty;
    logic [NWORDS-1:0][DATA_W-1:0]    rd_line;
    logic                             wr_en;
    logic [INDEX_BITS-1:0]            wr_idx;
    logic [WORD_OFF_BITS-1:0]         wr_word;
    logic [DATA_W-1:0]                wr_data;
    logic                             set_dirty;
    logic                             fill_done;

    logic access;
    logic line_hit;
    logic last_beat;

    // While a miss is in flight the read port follows the latched line, so
    // a request that changes mid-burst cannot disturb the victim data/tag.
    assign rd_idx    = (state == IDLE) ? cpu_idx : req_idx;
    assign access    = mem_read | mem_write;
    assign line_hit  = (state == IDLE) && rd_valid && (rd_tag == cpu_tag);
    assign hit       = !access || line_hit;
    assign rdata     = mem_read ? rd_line[cpu_word] : '0;
    assign last_beat = (beat == {WORD_OFF_BITS{1'b1}});

    dcache_line_store #(
        .INDEX_BITS    (INDEX_BITS),
        .WORD_OFF_BITS (WORD_OFF_BITS),
        .TAG_BITS      (TAG_BITS),
        .DATA_W        (DATA_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (rd_idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .set_dirty (set_dirty),
        .fill_done (fill_done),
        .fill_tag  (req_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= '0;
            req_tag <= '0;
            req_idx <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            if (latch_req) begin
                req_tag <= cpu_tag;
                req_idx <= cpu_idx;
            end
        end
    end

    // Memory-port outputs decode purely from state/beat/latched line, so they
    // stay stable until ack and drop to zero the instant reset forces IDLE.
    always_comb begin
        state_n       = state;
        beat_n        = beat;
        latch_req     = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = cpu_idx;
        wr_word       = cpu_word;
        wr_data       = wdata;
        set_dirty     = 1'b0;
        fill_done     = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        case (state)
            IDLE: begin
                if (access && !line_hit) begin
                    latch_req = 1'b1;
                    beat_n    = '0;
                    state_n   = (rd_valid && rd_dirty) ? WBACK : FILL;
                end else if (mem_write && line_hit) begin
                    wr_en     = 1'b1;
                    set_dirty = 1'b1;
                end
            end

            WBACK: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {rd_tag, req_idx, beat, {OFFSET_LSB{1'b0}}};
                mem.mem_wdata = rd_line[beat];
                if (mem.mem_ack) begin
                    beat_n = beat + 1'b1;
                    if (last_beat) begin
                        state_n = FILL;
                    end
                end
            end

            FILL: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = {req_tag, req_idx, beat, {OFFSET_LSB{1'b0}}};
                if (mem.mem_ack) begin
                    wr_en   = 1'b1;
                    wr_idx  = req_idx;
                    wr_word = beat;
                    wr_data = mem.mem_rdata;
                    beat_n  = beat + 1'b1;
                    if (last_beat) begin
                        fill_done = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
//   Directed bench for dcache_ctrl: cold miss, warm hit, store hit, combined
//   read/write, dirty-victim write-back, stalled fill, reset mid write-back.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    logic        hit;

    int total = 0;
    int bad = 0;

    dcache_ctrl_if #(.ADDR_W(64), .DATA_W(64)) mif ();

    dcache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .hit       (hit),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns at negedge+1 with inputs settled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Check the pending beat, acknowledge it for one cycle, and advance.
    task automatic serve(input string tag, input logic we, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] rd);
        check({tag, " req"}, {63'd0, mif.mem_req}, 64'd1);
        check({tag, " we"}, {63'd0, mif.mem_we}, {63'd0, we});
        check({tag, " addr"}, mif.mem_addr, a);
        if (we) check({tag, " wdata"}, mif.mem_wdata, wd);
        check({tag, " stall"}, {63'd0, hit}, 64'd0);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rd;
        @(posedge clk);
        #1;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst hit", {63'd0, hit}, 64'd1);
        check("rst mem_req", {63'd0, mif.mem_req}, 64'd0);
        check("rst mem_we", {63'd0, mif.mem_we}, 64'd0);
        check("rst mem_addr", mif.mem_addr, 64'd0);
        check("rst mem_wdata", mif.mem_wdata, 64'd0);
        check("rst rdata", rdata, 64'd0);
        rst_n = 1'b1;
        step();

        // 1: cold read 0x40, clean fill A0..A3
        mem_read = 1'b1;
        addr     = 64'h40;
        #1;
        check("t1 miss", {63'd0, hit}, 64'd0);
        check("t1 idle req", {63'd0, mif.mem_req}, 64'd0);
        step();
        serve("t1 b0", 1'b0, 64'h40, 64'h0, 64'hA0);
        serve("t1 b1", 1'b0, 64'h48, 64'h0, 64'hA1);
        serve("t1 b2", 1'b0, 64'h50, 64'h0, 64'hA2);
        serve("t1 b3", 1'b0, 64'h58, 64'h0, 64'hA3);
        check("t1 hit", {63'd0, hit}, 64'd1);
        check("t1 rdata", rdata, 64'hA0);
        check("t1 req off", {63'd0, mif.mem_req}, 64'd0);

        // 2: warm read 0x48
        addr = 64'h48;
        #1;
        check("t2 hit", {63'd0, hit}, 64'd1);
        check("t2 rdata", rdata, 64'hA1);
        check("t2 req", {63'd0, mif.mem_req}, 64'd0);

        // 3: store hit 0x50, then load it back
        mem_read  = 1'b0;
        mem_write = 1'b1;
        addr      = 64'h50;
        wdata     = 64'hDEAD;
        #1;
        check("t3 wr hit", {63'd0, hit}, 64'd1);
        check("t3 rdata idle", rdata, 64'd0);
        step();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        #1;
        check("t3 rd hit", {63'd0, hit}, 64'd1);
        check("t3 rdata", rdata, 64'hDEAD);
        check("t3 dirty", {63'd0, dut.u_store.dirty[2]}, 64'd1);

        // Read and write together: load shows the old word, store lands
        mem_write = 1'b1;
        addr      = 64'h58;
        wdata     = 64'h55;
        #1;
        check("rw hit", {63'd0, hit}, 64'd1);
        check("rw old", rdata, 64'hA3);
        step();
        mem_write = 1'b0;
        #1;
        check("rw new", rdata, 64'h55);

        // 4: read 0x450 evicts dirty line at idx 2
        addr = 64'h450;
        #1;
        check("t4 miss", {63'd0, hit}, 64'd0);
        step();
        serve("t4 wb0", 1'b1, 64'h40, 64'hA0, 64'h0);
        serve("t4 wb1", 1'b1, 64'h48, 64'hA1, 64'h0);
        serve("t4 wb2", 1'b1, 64'h50, 64'hDEAD, 64'h0);
        serve("t4 wb3", 1'b1, 64'h58, 64'h55, 64'h0);
        serve("t4 f0", 1'b0, 64'h440, 64'h0, 64'hB0);
        serve("t4 f1", 1'b0, 64'h448, 64'h0, 64'hB1);
        serve("t4 f2", 1'b0, 64'h450, 64'h0, 64'hB2);
        serve("t4 f3", 1'b0, 64'h458, 64'h0, 64'hB3);
        check("t4 hit", {63'd0, hit}, 64'd1);
        check("t4 rdata", rdata, 64'hB2);
        check("t4 clean", {63'd0, dut.u_store.dirty[2]}, 64'd0);

        // 5: fill with ack withheld for 10 cycles after beat 1
        addr = 64'h848;
        #1;
        check("t5 miss", {63'd0, hit}, 64'd0);
        step();
        serve("t5 f0", 1'b0, 64'h840, 64'h0, 64'hC0);
        serve("t5 f1", 1'b0, 64'h848, 64'h0, 64'hC1);
        for (int i = 0; i < 10; i++) begin
            check("t5 hold req", {63'd0, mif.mem_req}, 64'd1);
            check("t5 hold we", {63'd0, mif.mem_we}, 64'd0);
            check("t5 hold addr", mif.mem_addr, 64'h850);
            check("t5 hold stall", {63'd0, hit}, 64'd0);
            step();
        end
        serve("t5 f2", 1'b0, 64'h850, 64'h0, 64'hC2);
        serve("t5 f3", 1'b0, 64'h858, 64'h0, 64'hC3);
        check("t5 hit", {63'd0, hit}, 64'd1);
        check("t5 rdata", rdata, 64'hC1);

        // 6: dirty the line, miss on 0x40, reset during write-back beat 2
        mem_read  = 1'b0;
        mem_write = 1'b1;
        addr      = 64'h840;
        wdata     = 64'h77;
        #1;
        check("t6 wr hit", {63'd0, hit}, 64'd1);
        step();
        mem_write = 1'b0;
        mem_read  = 1'b1;
        addr      = 64'h40;
        #1;
        check("t6 miss", {63'd0, hit}, 64'd0);
        step();
        serve("t6 wb0", 1'b1, 64'h840, 64'h77, 64'h0);
        serve("t6 wb1", 1'b1, 64'h848, 64'hC1, 64'h0);
        check("t6 wb2 req", {63'd0, mif.mem_req}, 64'd1);
        check("t6 wb2 addr", mif.mem_addr, 64'h850);
        rst_n = 1'b0;
        #1;
        check("t6 rst req", {63'd0, mif.mem_req}, 64'd0);
        check("t6 rst we", {63'd0, mif.mem_we}, 64'd0);
        check("t6 rst addr", mif.mem_addr, 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("t6 post miss", {63'd0, hit}, 64'd0);
        check("t6 post idle", {63'd0, mif.mem_req}, 64'd0);
        step();
        serve("t6 f0", 1'b0, 64'h40, 64'h0, 64'hD0);
        serve("t6 f1", 1'b0, 64'h48, 64'h0, 64'hD1);
        serve("t6 f2", 1'b0, 64'h50, 64'h0, 64'hD2);
        serve("t6 f3", 1'b0, 64'h58, 64'h0, 64'hD3);
        check("t6 hit", {63'd0, hit}, 64'd1);
        check("t6 rdata", rdata, 64'hD0);
        mem_read = 1'b0;
        #1;
        check("t6 no access", {63'd0, hit}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
